console_monitor: RTL and testbench

CONSOLE_MONITOR -- requirements
Module: console_monitor

---
 rtl/console_monitor.sv | 144 ++++++++++++++
 tb/tb_console_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/console_monitor.sv
// Console monitor: buffers console bytes written by the bbq core in a small
// first-word fall-through FIFO and tracks the end-of-test status (run, pass,
// fail or timeout) together with run-time and dropped-byte statistics.
module console_monitor #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_LEN        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         console_we,
  input  logic [XLEN-1:0]              console_wdata,
  input  logic                         test_passed,
  input  logic                         error,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic [CNT_LEN-1:0]           drops,
  output logic [CNT_LEN-1:0]           cycles,
  output logic                         done,
  output logic                         passed,
  output logic                         failed,
  output logic                         timed_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Value of cycles on the last RUN cycle before the timeout fires.
  localparam logic [63:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 64'd0 : (64'(TIMEOUT_CYCLES) - 64'd1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t state;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop;
  logic          push;
  logic          drop;

  // Only the low byte of the console write carries a character.
  if (XLEN > 8) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^console_wdata[XLEN-1:8];
  end

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // Handshake decode: a full FIFO still takes a byte when the head leaves in the same cycle.
  always_comb begin
    pop  = out_valid && out_ready;
    push = console_we && ((level != FULL_LEVEL) || pop);
    drop = console_we && (level == FULL_LEVEL) && !pop;
  end

  // Byte storage, wrapping pointers and occupancy; storage is cleared so out_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= console_wdata[7:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (!push && pop) begin
        level <= level - LW'(1);
      end
    end
  end

  // Sticky overflow flag and saturating count of bytes lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drops    <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drops != '1) begin
        drops <= drops + CNT_LEN'(1);
      end
    end
  end

  // Test status machine with registered status flags and the RUN-time counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      cycles    <= '0;
      done      <= 1'b0;
      passed    <= 1'b0;
      failed    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cycles != '1) begin
            cycles <= cycles + CNT_LEN'(1);
          end
          if (error) begin
            done <= 1'b1;
            if (test_passed) begin
              state  <= ST_PASS;
              passed <= 1'b1;
            end else begin
              state  <= ST_FAIL;
              failed <= 1'b1;
            end
          end else if (TIMEOUT_EN && (64'(cycles) == TIMEOUT_LAST)) begin
            state     <= ST_TIMEOUT;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_monitor.sv
// Self-checking bench for console_monitor: directed scenarios plus a random
// phase, every cycle compared against a queue-based behavioural model.
module tb_console_monitor;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 16;
  localparam int TO       = 10;
  localparam int CNT_LEN  = 4;
  localparam int LW       = $clog2(DEPTH+1);
  localparam int CNT_MAX  = (1 << CNT_LEN) - 1;

  localparam int M_RUN     = 0;
  localparam int M_PASS    = 1;
  localparam int M_FAIL    = 2;
  localparam int M_TIMEOUT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               console_we;
  logic [XLEN-1:0]    console_wdata;
  logic               test_passed;
  logic               error;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_ready;
  logic [LW-1:0]      level;
  logic               overflow;
  logic [CNT_LEN-1:0] drops;
  logic [CNT_LEN-1:0] cycles;
  logic               done;
  logic               passed;
  logic               failed;
  logic               timed_out;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  byte unsigned q[$];
  bit ov_m;
  int drops_m;
  int cyc_m;
  int st_m;
  bit pushed_m;

  // Free-running clock
  always #5 clk = ~clk;

  console_monitor #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO),
    .CNT_LEN(CNT_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .console_we(console_we),
    .console_wdata(console_wdata),
    .test_passed(test_passed),
    .error(error),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow),
    .drops(drops),
    .cycles(cycles),
    .done(done),
    .passed(passed),
    .failed(failed),
    .timed_out(timed_out)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("level",     32'(level),     32'(q.size()));
    checkValue("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      checkValue("out_data", 32'(out_data), 32'(q[0]));
    end else if (!pushed_m) begin
      checkValue("out_data_reset", 32'(out_data), 32'h00);
    end
    checkValue("overflow",  32'(overflow),  32'(ov_m));
    checkValue("drops",     32'(drops),     32'(drops_m));
    checkValue("cycles",    32'(cycles),    32'(cyc_m));
    checkValue("done",      32'(done),      32'(st_m != M_RUN));
    checkValue("passed",    32'(passed),    32'(st_m == M_PASS));
    checkValue("failed",    32'(failed),    32'(st_m == M_FAIL));
    checkValue("timed_out", 32'(timed_out), 32'(st_m == M_TIMEOUT));
  endtask

  // Drive one cycle of inputs, advance the model with the same inputs, then compare.
  task automatic applyStimulus(input bit rst, input bit we, input logic [7:0] b,
                               input bit rdy, input bit err, input bit tp);
    int lvl;
    bit pop_m;
    reset         = rst;
    console_we    = we;
    console_wdata = $urandom();
    console_wdata[7:0] = b;
    out_ready     = rdy;
    error         = err;
    test_passed   = tp;
    if (rst) begin
      q.delete();
      ov_m     = 1'b0;
      drops_m  = 0;
      cyc_m    = 0;
      st_m     = M_RUN;
      pushed_m = 1'b0;
    end else begin
      lvl   = q.size();
      pop_m = (lvl > 0) && rdy;
      if (pop_m) void'(q.pop_front());
      if (we) begin
        if (lvl < DEPTH || pop_m) begin
          q.push_back(b);
          pushed_m = 1'b1;
        end else begin
          ov_m = 1'b1;
          if (drops_m < CNT_MAX) drops_m++;
        end
      end
      if (st_m == M_RUN) begin
        if (err) st_m = tp ? M_PASS : M_FAIL;
        else if (cyc_m == TO - 1) st_m = M_TIMEOUT;
        if (cyc_m < CNT_MAX) cyc_m++;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; console_we = 1'b0; console_wdata = '0;
    out_ready = 1'b0; error = 1'b0; test_passed = 1'b0;

    $display("[TB] reset state");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    applyStimulus(1, 1, 8'h55, 1, 1, 1);

    $display("[TB] OK newline stream");
    applyStimulus(0, 1, 8'h4F, 1, 0, 0);
    applyStimulus(0, 1, 8'h4B, 1, 0, 0);
    applyStimulus(0, 1, 8'h0A, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0);

    $display("[TB] overflow by two");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 18; i++) applyStimulus(0, 1, 8'($urandom()), 0, 0, 0);
    checkValue("drops_after_18", 32'(drops), 32'd2);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0);

    $display("[TB] push and pop while full");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'(i + 1), 0, 0, 0);
    applyStimulus(0, 1, 8'hA5, 1, 0, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0);
    checkValue("marker_is_16th", 32'(out_data), 32'hA5);
    applyStimulus(0, 0, 8'h00, 1, 0, 0);

    $display("[TB] drop counter saturation");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 36; i++) applyStimulus(0, 1, 8'($urandom()), 0, 0, 0);

    $display("[TB] pass then ignored fail");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 1);
    applyStimulus(0, 1, 8'h21, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 1, 0);
    checkValue("cycles_frozen", 32'(cycles), 32'd6);

    $display("[TB] timeout");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);

    $display("[TB] reset discards buffered bytes");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'($urandom()), 0, 0, 0);
    applyStimulus(1, 1, 8'h77, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);

    $display("[TB] random traffic");
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 99) < 60,
                    8'($urandom()),
                    $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
